// File: rtl/bt_cmd_pkg.sv
// Shared constants, field layout and state encoding for the Bluetooth motor command decoder.
package bt_cmd_pkg;

  localparam logic [7:0] HEADER    = 8'hAA;
  localparam logic [7:0] CHK_KEY   = 8'h55;
  localparam logic [3:0] SPEED_MAX = 4'd9;

  // Command word layout: {M1,M2,M3,M4,SpeedL,SpeedR}, each Mx = {enable,dir}
  localparam int M1_LSB    = 14;
  localparam int M2_LSB    = 12;
  localparam int M3_LSB    = 10;
  localparam int M4_LSB    = 8;
  localparam int SPD_L_LSB = 4;
  localparam int SPD_R_LSB = 0;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_HI   = 2'd1;
  localparam state_t S_LO   = 2'd2;
  localparam state_t S_CHK  = 2'd3;

  function automatic logic [3:0] clamp_speed(input logic [3:0] spd);
    if (spd > SPEED_MAX) begin
      return SPEED_MAX;
    end else begin
      return spd;
    end
  endfunction

  function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
    return hi ^ lo ^ CHK_KEY;
  endfunction

  function automatic logic [15:0] clamp_cmd(input logic [15:0] raw);
    logic [15:0] cmd;
    cmd = raw;
    cmd[SPD_L_LSB +: 4] = clamp_speed(raw[SPD_L_LSB +: 4]);
    cmd[SPD_R_LSB +: 4] = clamp_speed(raw[SPD_R_LSB +: 4]);
    return cmd;
  endfunction

endpackage

// File: rtl/bt_command_decoder_timeout_ctr.sv
// Saturating idle counter: expired is a one-cycle strobe on the LIMIT-th enabled
// cycle since the last clear; it then holds until cleared, so it never re-fires.
module cmd_timeout_ctr #(
  parameter int LIMIT = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);
  localparam logic [W-1:0]   FULL = W'(LIMIT);
  localparam logic [W-1:0]   ONE  = W'(1);

  logic [W-1:0] count_r;

  // Idle cycle counter; clear has priority so a same-cycle event cancels expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != FULL)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && !clear && (count_r == LAST);

endmodule

// File: rtl/bt_command_decoder.sv
// Frame parser for HEADER,HI,LO,CHK command frames from the UART receiver.
// Optional watchdog forced-stop is enabled by defining BT_CMD_WATCHDOG_EN.
module bt_command_decoder
  import bt_cmd_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 100_000,
  parameter int WDOG_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] command,
  output logic        cmd_update,
  output logic        frame_err,
  output logic        wdog_trip,
  output logic        busy
);

  state_t      state_r, state_nxt_s;
  logic [7:0]  hi_r, hi_nxt_s;
  logic [7:0]  lo_r, lo_nxt_s;
  logic [15:0] command_r;
  logic        cmd_update_r, frame_err_r, wdog_trip_r, busy_r;
  logic        commit_s, chk_bad_s;
  logic        byte_expired_s, wdog_expired_s;

  cmd_timeout_ctr #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (busy_r),
    .expired (byte_expired_s)
  );

`ifdef BT_CMD_WATCHDOG_EN
  cmd_timeout_ctr #(.LIMIT(WDOG_CYCLES)) u_wdog_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (commit_s),
    .enable  (1'b1),
    .expired (wdog_expired_s)
  );
`else
  // No watchdog: expiry is constant false for any legal WDOG_CYCLES
  assign wdog_expired_s = (WDOG_CYCLES < 32'sd0);
`endif

  // Parser next-state; a byte in the timer expiry cycle wins over the timeout
  always_comb begin
    state_nxt_s = state_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    commit_s    = 1'b0;
    chk_bad_s   = 1'b0;
    if (rx_valid) begin
      case (state_r)
        S_IDLE: begin
          if (rx_data == HEADER) begin
            state_nxt_s = S_HI;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_HI: begin
          hi_nxt_s    = rx_data;
          state_nxt_s = S_LO;
        end
        S_LO: begin
          lo_nxt_s    = rx_data;
          state_nxt_s = S_CHK;
        end
        S_CHK: begin
          state_nxt_s = S_IDLE;
          if (rx_data == frame_chk(hi_r, lo_r)) begin
            commit_s = 1'b1;
          end else begin
            chk_bad_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end else if (byte_expired_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Parser state and captured payload bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      hi_r    <= 8'h00;
      lo_r    <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
    end
  end

  // Command register and status pulses; a commit beats a watchdog stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      command_r    <= 16'h0000;
      cmd_update_r <= 1'b0;
      frame_err_r  <= 1'b0;
      wdog_trip_r  <= 1'b0;
    end else begin
      if (commit_s) begin
        command_r <= clamp_cmd({hi_r, lo_r});
      end else if (wdog_expired_s) begin
        command_r <= 16'h0000;
      end else begin
        command_r <= command_r;
      end
      cmd_update_r <= commit_s;
      frame_err_r  <= chk_bad_s | byte_expired_s;
      wdog_trip_r  <= wdog_expired_s & ~commit_s;
    end
  end

  assign command    = command_r;
  assign cmd_update = cmd_update_r;
  assign frame_err  = frame_err_r;
  assign wdog_trip  = wdog_trip_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_bt_command_decoder.sv
// Directed bench for bt_command_decoder with shortened timeouts; honours BT_CMD_WATCHDOG_EN.
module tb_bt_command_decoder;

  localparam int BT = 20;
  localparam int WD = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] command;
  logic        cmd_update, frame_err, wdog_trip, busy;

  int n_cmp = 0;
  int n_bad = 0;

  bt_command_decoder #(.BYTE_TIMEOUT(BT), .WDOG_CYCLES(WD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .command    (command),
    .cmd_update (cmd_update),
    .frame_err  (frame_err),
    .wdog_trip  (wdog_trip),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Present one byte for one clock; returns at the negedge after it was sampled
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++; if (command !== 16'h0000) begin n_bad++; $display("FAIL reset_command: got %h expected 0000", command); end
    n_cmp++; if ({cmd_update, frame_err, wdog_trip, busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {cmd_update, frame_err, wdog_trip, busy}); end
  endtask

  task automatic test_good_frame;
    send_byte(8'hAA); send_byte(8'hC5); send_byte(8'h59);
    n_cmp++; if (command !== 16'h0000) begin n_bad++; $display("FAIL good_before_chk: got %h expected 0000", command); end
    send_byte(8'hC9);
    n_cmp++; if (command !== 16'hC559) begin n_bad++; $display("FAIL good_command: got %h expected C559", command); end
    n_cmp++; if ({cmd_update, frame_err, busy} !== 3'b100) begin n_bad++; $display("FAIL good_flags: got %b expected 100", {cmd_update, frame_err, busy}); end
    @(negedge clk);
    n_cmp++; if (cmd_update !== 1'b0) begin n_bad++; $display("FAIL good_single_pulse: got %b expected 0", cmd_update); end
  endtask

  task automatic test_clamp;
    send_byte(8'hAA); send_byte(8'hFF); send_byte(8'hAF); send_byte(8'h05);
    n_cmp++; if (command !== 16'hFF99) begin n_bad++; $display("FAIL clamp_command: got %h expected FF99", command); end
    n_cmp++; if (cmd_update !== 1'b1) begin n_bad++; $display("FAIL clamp_update: got %b expected 1", cmd_update); end
  endtask

  task automatic test_bad_checksum;
    send_byte(8'hAA); send_byte(8'hC5); send_byte(8'h59); send_byte(8'h00);
    n_cmp++; if (command !== 16'hFF99) begin n_bad++; $display("FAIL badchk_command: got %h expected FF99", command); end
    n_cmp++; if ({cmd_update, frame_err, busy} !== 3'b010) begin n_bad++; $display("FAIL badchk_flags: got %b expected 010", {cmd_update, frame_err, busy}); end
    @(negedge clk);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL badchk_single_pulse: got %b expected 0", frame_err); end
  endtask

  task automatic test_timeout;
    send_byte(8'hAA); send_byte(8'hC5);
    idle(BT - 1);
    n_cmp++; if ({busy, frame_err} !== 2'b10) begin n_bad++; $display("FAIL timeout_early: got %b expected 10", {busy, frame_err}); end
    @(negedge clk);
    n_cmp++; if ({busy, frame_err} !== 2'b01) begin n_bad++; $display("FAIL timeout_expire: got %b expected 01", {busy, frame_err}); end
    send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34); send_byte(8'h73);
    n_cmp++; if (command !== 16'h1234) begin n_bad++; $display("FAIL timeout_recover: got %h expected 1234", command); end
  endtask

  task automatic test_timeout_edge;
    send_byte(8'hAA);
    idle(BT - 1);
    send_byte(8'h21);
    n_cmp++; if ({busy, frame_err} !== 2'b10) begin n_bad++; $display("FAIL edge_byte_wins: got %b expected 10", {busy, frame_err}); end
    send_byte(8'h43); send_byte(8'h37);
    n_cmp++; if (command !== 16'h2143) begin n_bad++; $display("FAIL edge_command: got %h expected 2143", command); end
  endtask

  task automatic test_stray_byte;
    send_byte(8'h12);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stray_busy: got %b expected 0", busy); end
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFE);
    n_cmp++; if (command !== 16'hAA01) begin n_bad++; $display("FAIL stray_command: got %h expected AA01", command); end
  endtask

  task automatic test_back_to_back;
    send_byte(8'hAA); send_byte(8'hC5); send_byte(8'h59); send_byte(8'hC9);
    n_cmp++; if (command !== 16'hC559) begin n_bad++; $display("FAIL b2b_first: got %h expected C559", command); end
    send_byte(8'hAA); send_byte(8'hFF); send_byte(8'hAF); send_byte(8'h05);
    n_cmp++; if (command !== 16'hFF99) begin n_bad++; $display("FAIL b2b_second: got %h expected FF99", command); end
  endtask

  task automatic test_watchdog;
    int trips;
    trips = 0;
    send_byte(8'hAA); send_byte(8'hC5); send_byte(8'h59); send_byte(8'hC9);
`ifdef BT_CMD_WATCHDOG_EN
    idle(WD - 1);
    n_cmp++; if ({command, wdog_trip} !== {16'hC559, 1'b0}) begin n_bad++; $display("FAIL wdog_early: got %h/%b expected C559/0", command, wdog_trip); end
    @(negedge clk);
    n_cmp++; if ({command, wdog_trip} !== {16'h0000, 1'b1}) begin n_bad++; $display("FAIL wdog_trip: got %h/%b expected 0000/1", command, wdog_trip); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wdog_trip === 1'b1) trips++;
    end
    n_cmp++; if (trips !== 0) begin n_bad++; $display("FAIL wdog_retrip: got %0d expected 0", trips); end
`else
    for (int i = 0; i < WD + 50; i++) begin
      @(negedge clk);
      if (wdog_trip !== 1'b0) trips++;
    end
    n_cmp++; if (trips !== 0) begin n_bad++; $display("FAIL wdog_tied: got %0d expected 0", trips); end
    n_cmp++; if (command !== 16'hC559) begin n_bad++; $display("FAIL wdog_hold: got %h expected C559", command); end
`endif
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34); send_byte(8'h73);
    send_byte(8'hAA); send_byte(8'hC5);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({command, busy} !== {16'h0000, 1'b0}) begin n_bad++; $display("FAIL midrst_async: got %h/%b expected 0000/0", command, busy); end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h59); send_byte(8'hC9);
    n_cmp++; if ({command, cmd_update} !== {16'h0000, 1'b0}) begin n_bad++; $display("FAIL midrst_discard: got %h/%b expected 0000/0", command, cmd_update); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    test_reset;
    rst = 1'b0;
    idle(1);
    test_good_frame;
    test_clamp;
    test_bad_checksum;
    test_timeout;
    test_timeout_edge;
    test_stray_byte;
    test_back_to_back;
    test_watchdog;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
